// File: rtl/prm_pkg.sv
// Shared definitions for the PRM edge-checker front end: code width,
// default bank geometry and the frame-accumulator state encoding.
package prm_pkg;

  localparam int CODE_W        = 15;
  localparam int DEF_NUM_EDGES = 64;
  localparam int DEF_CNT_W     = 16;

  typedef enum logic [1:0] {
    SCAN  = 2'd0,
    FLUSH = 2'd1,
    HOLD  = 2'd2
  } edge_acc_state_t;

endpackage

// File: rtl/prm_mask_accum.sv
// Blocked-edge accumulator for one scan frame: ORs checker masks into a bitmap
// and keeps a saturating count of accepted codes with a sticky saturation flag.
module prm_mask_accum
  import prm_pkg::*;
#(
  parameter int NUM_EDGES = DEF_NUM_EDGES,
  parameter int CNT_W     = DEF_CNT_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 fold,
  input  logic                 inc,
  input  logic                 clear,
  input  logic [NUM_EDGES-1:0] mask,
  output logic [NUM_EDGES-1:0] accum,
  output logic [CNT_W-1:0]     count,
  output logic                 sat
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      accum <= '0;
      count <= '0;
      sat   <= 1'b0;
    end else if (clear) begin
      accum <= '0;
      count <= '0;
      sat   <= 1'b0;
    end else begin
      if (fold) accum <= accum | mask;
      if (inc) begin
        count <= sat_inc(count);
        if (count == CNT_MAX) sat <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/prm_edge_accum.sv
// Drives obstacle codes into the PRM edge-checker bank and folds the bank's
// edge masks over a frame into a blocked-edge bitmap handed to the roadmap update.
module prm_edge_accum
  import prm_pkg::*;
#(
  parameter int NUM_EDGES = DEF_NUM_EDGES,
  parameter int CNT_W     = DEF_CNT_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 code_valid,
  output logic                 code_ready,
  input  logic [CODE_W-1:0]    code_data,
  input  logic                 code_last,
  output logic [CODE_W-1:0]    chk_code,
  input  logic [NUM_EDGES-1:0] chk_mask,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [NUM_EDGES-1:0] res_blocked,
  output logic                 res_any,
  output logic [CNT_W-1:0]     res_count,
  output logic                 res_sat
);

  edge_acc_state_t      state;
  logic                 vld_p1;
  logic                 accept;
  logic                 handshake;
  logic [NUM_EDGES-1:0] accum;

  assign accept    = code_valid & code_ready;
  assign handshake = res_valid & res_ready;

  // Stage p0 -> p1: accepted code goes to the bank; its mask returns next cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chk_code <= '0;
      vld_p1   <= 1'b0;
    end else begin
      vld_p1 <= accept;
      if (accept) chk_code <= code_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= SCAN;
      code_ready <= 1'b1;
      res_valid  <= 1'b0;
    end else begin
      case (state)
        SCAN: begin
          if (accept && code_last) begin
            state      <= FLUSH;
            code_ready <= 1'b0;
          end
        end
        FLUSH: begin
          state     <= HOLD;
          res_valid <= 1'b1;
        end
        HOLD: begin
          if (res_ready) begin
            state      <= SCAN;
            res_valid  <= 1'b0;
            code_ready <= 1'b1;
          end
        end
        default: begin
          state      <= SCAN;
          res_valid  <= 1'b0;
          code_ready <= 1'b1;
        end
      endcase
    end
  end

  // Stage p1 -> p2: mask fold into the frame bitmap.
  prm_mask_accum #(
    .NUM_EDGES (NUM_EDGES),
    .CNT_W     (CNT_W)
  ) u_accum (
    .clk   (clk),
    .rst   (rst),
    .fold  (vld_p1),
    .inc   (accept),
    .clear (handshake),
    .mask  (chk_mask),
    .accum (accum),
    .count (res_count),
    .sat   (res_sat)
  );

  assign res_blocked = accum;
  assign res_any     = |accum;

endmodule

// File: tb/tb_prm_edge_accum.sv
// Directed bench for prm_edge_accum: a frame-level model predicts each frame's
// result and a per-cycle monitor compares both CNT_W variants against it.
module tb_prm_edge_accum;

  localparam int NE = 64;
  localparam logic [NE-1:0] GARB = '1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic code_valid = 1'b0;
  logic code_last = 1'b0;
  logic res_ready = 1'b0;
  logic [14:0] code_data = '0;
  logic [NE-1:0] chk_mask = GARB;

  logic a_code_ready, a_res_valid, a_res_any, a_res_sat;
  logic [14:0] a_chk_code;
  logic [NE-1:0] a_res_blocked;
  logic [15:0] a_res_count;

  logic b_code_ready, b_res_valid, b_res_any, b_res_sat;
  logic [14:0] b_chk_code;
  logic [NE-1:0] b_res_blocked;
  logic [2:0] b_res_count;

  always #5 clk = ~clk;

  prm_edge_accum #(.NUM_EDGES(NE), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .code_valid(code_valid), .code_ready(a_code_ready),
    .code_data(code_data), .code_last(code_last), .chk_code(a_chk_code),
    .chk_mask(chk_mask), .res_valid(a_res_valid), .res_ready(res_ready),
    .res_blocked(a_res_blocked), .res_any(a_res_any), .res_count(a_res_count),
    .res_sat(a_res_sat));

  prm_edge_accum #(.NUM_EDGES(NE), .CNT_W(3)) dut3 (
    .clk(clk), .rst(rst), .code_valid(code_valid), .code_ready(b_code_ready),
    .code_data(code_data), .code_last(code_last), .chk_code(b_chk_code),
    .chk_mask(chk_mask), .res_valid(b_res_valid), .res_ready(res_ready),
    .res_blocked(b_res_blocked), .res_any(b_res_any), .res_count(b_res_count),
    .res_sat(b_res_sat));

  int total = 0;
  int passed = 0;

  typedef struct {
    logic [NE-1:0] blocked;
    int            n;
  } exp_t;
  exp_t exp_q[$];

  logic [14:0]   fcode[0:15];
  logic [NE-1:0] fmask[0:15];

  logic [NE-1:0] cap_blocked;
  logic          cap_any, cap_sat, cap3_sat;
  logic [15:0]   cap_count;
  logic [2:0]    cap3_count;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Per-cycle monitor: while a result is presented it must equal the model's frame result.
  always @(negedge clk) begin
    if (!rst && (a_res_valid || b_res_valid)) begin
      if (exp_q.size() == 0) begin
        check("unexpected_res_valid", 64'd1, 64'd0);
      end else begin
        check("mon_valid16", a_res_valid, 1'b1);
        check("mon_valid3", b_res_valid, 1'b1);
        check("mon_blocked16", a_res_blocked, exp_q[0].blocked);
        check("mon_blocked3", b_res_blocked, exp_q[0].blocked);
        check("mon_any16", a_res_any, |exp_q[0].blocked);
        check("mon_any3", b_res_any, |exp_q[0].blocked);
        check("mon_count16", a_res_count, 64'(exp_q[0].n));
        check("mon_sat16", a_res_sat, 1'b0);
        check("mon_count3", b_res_count, 64'((exp_q[0].n > 7) ? 7 : exp_q[0].n));
        check("mon_sat3", b_res_sat, exp_q[0].n > 7);
        if (a_res_valid && res_ready) void'(exp_q.pop_front());
      end
    end
  end

  task automatic check_reset_values();
    check("rst_chk_code", a_chk_code, 15'd0);
    check("rst_res_valid", a_res_valid, 1'b0);
    check("rst_res_blocked", a_res_blocked, 64'd0);
    check("rst_res_any", a_res_any, 1'b0);
    check("rst_res_count", a_res_count, 16'd0);
    check("rst_res_sat", a_res_sat, 1'b0);
    check("rst_res_count3", b_res_count, 3'd0);
    check("rst_res_valid3", b_res_valid, 1'b0);
  endtask

  // Sends fcode/fmask[0..n-1] as one frame, then stays in HOLD for hold_low cycles.
  task automatic send_frame(input int n, input int hold_low, input logic valid_in_hold);
    exp_t e;
    int zc;
    int cyc;
    e.blocked = '0;
    for (int i = 0; i < n; i++) e.blocked |= fmask[i];
    e.n = n;
    exp_q.push_back(e);
    for (int i = 0; i < n; i++) begin
      code_valid = 1'b1;
      code_data  = fcode[i];
      code_last  = (i == n - 1);
      chk_mask   = (i == 0) ? GARB : fmask[i-1];
      check("code_ready_scan", a_code_ready, 1'b1);
      @(posedge clk); #1;
      check("chk_code", a_chk_code, fcode[i]);
    end
    code_valid = valid_in_hold;
    code_last  = valid_in_hold;
    code_data  = 15'h7ABC;
    chk_mask   = fmask[n-1];
    zc = 0;
    cyc = 0;
    while (a_code_ready == 1'b0 && cyc < 20) begin
      zc++;
      if (cyc == 0) check("res_valid_flush", a_res_valid, 1'b0);
      if (cyc == 1) begin
        check("res_valid_latency", a_res_valid, 1'b1);
        cap_blocked = a_res_blocked;
        cap_any     = a_res_any;
        cap_count   = a_res_count;
        cap_sat     = a_res_sat;
        cap3_count  = b_res_count;
        cap3_sat    = b_res_sat;
      end
      res_ready = (hold_low == 0) || (cyc >= hold_low + 1);
      if (cyc >= 1) chk_mask = GARB;
      @(posedge clk); #1;
      cyc++;
    end
    check("ready_low_cycles", 64'(zc), 64'(hold_low + 2));
    check("res_valid_after_hs", a_res_valid, 1'b0);
    check("code_ready_after_hs", a_code_ready, 1'b1);
    res_ready  = 1'b0;
    code_valid = 1'b0;
    code_last  = 1'b0;
    chk_mask   = GARB;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check_reset_values();
    #2 rst = 1'b0;
    @(posedge clk); #1;
    check("code_ready_post_rst", a_code_ready, 1'b1);

    // One-code frame.
    fcode[0] = 15'h4A15; fmask[0] = 64'h5;
    send_frame(1, 0, 1'b0);
    check("t1_blocked", cap_blocked, 64'h5);
    check("t1_any", cap_any, 1'b1);
    check("t1_count", cap_count, 16'd1);

    // Back-to-back four-code frame.
    fcode[0] = 15'h0001; fmask[0] = 64'h1;
    fcode[1] = 15'h0002; fmask[1] = 64'h2;
    fcode[2] = 15'h0003; fmask[2] = 64'h0;
    fcode[3] = 15'h4000; fmask[3] = 64'h8;
    send_frame(4, 0, 1'b0);
    check("t2_blocked", cap_blocked, 64'hB);
    check("t2_count", cap_count, 16'd4);

    repeat (2) @(posedge clk);
    #1;

    // Ten codes, all masks zero; CNT_W=3 instance saturates.
    for (int i = 0; i < 10; i++) begin
      fcode[i] = (i == 0) ? 15'h7FFF : 15'(i * 'h111);
      fmask[i] = '0;
    end
    send_frame(10, 0, 1'b0);
    check("t3_blocked", cap_blocked, 64'h0);
    check("t3_any", cap_any, 1'b0);
    check("t3_count", cap_count, 16'd10);
    check("t3_count3", cap3_count, 3'd7);
    check("t3_sat3", cap3_sat, 1'b1);

    // Result held five cycles with upstream pushing.
    fcode[0] = 15'h1111; fmask[0] = 64'h100;
    fcode[1] = 15'h2222; fmask[1] = 64'h8000_0000_0000_0000;
    fcode[2] = 15'h3333; fmask[2] = 64'h100;
    send_frame(3, 5, 1'b1);
    check("t4_blocked", cap_blocked, 64'h8000_0000_0000_0100);

    // Nine-code frame must start from an empty bitmap.
    for (int i = 0; i < 9; i++) begin
      fcode[i] = 15'(i + 'h20);
      fmask[i] = 64'h1 << (i + 16);
    end
    send_frame(9, 0, 1'b0);
    check("t5_blocked", cap_blocked, 64'h1FF_0000);
    check("t5_count", cap_count, 16'd9);
    check("t5_sat", cap_sat, 1'b0);
    check("t5_count3", cap3_count, 3'd7);
    check("t5_sat3", cap3_sat, 1'b1);

    // Partial frame discarded by reset.
    for (int i = 0; i < 3; i++) begin
      code_valid = 1'b1;
      code_last  = 1'b0;
      code_data  = 15'(i + 'h50);
      chk_mask   = (i == 0) ? GARB : 64'hF0;
      @(posedge clk); #1;
    end
    code_valid = 1'b0;
    chk_mask   = 64'hF0;
    #2 rst = 1'b1;
    #1;
    check_reset_values();
    @(posedge clk); #3;
    rst = 1'b0;
    chk_mask = GARB;
    @(posedge clk); #1;
    check("code_ready_post_rst2", a_code_ready, 1'b1);

    fcode[0] = 15'h0ABC; fmask[0] = 64'h2;
    send_frame(1, 0, 1'b0);
    check("t6_blocked", cap_blocked, 64'h2);
    check("t6_count", cap_count, 16'd1);

    repeat (3) @(posedge clk);
    #1;
    check("all_results_seen", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/prm_edge_accum.md
# prm_edge_accum

Streams 15-bit obstacle voxel codes into the PRM edge-checker bank (the `prm_oblgc_chk*` instances, one per roadmap edge) and ORs every checker's `edge_mask` over a scan frame. At frame end it presents the resulting blocked-edge bitmap to the roadmap/graph update logic. It sits directly upstream of the checker bank, which it drives, and also consumes the bank's outputs.

## Interface
- NUM_EDGES, 64, number of checker instances / edge_mask bits folded in parallel
- CODE_W, 15, obstacle code width; bit 0 drives checker input A, bit 14 drives O
- CNT_W, 16, width of per-frame code counter

- clk  in  1  sole clock
- rst  in  1  asynchronous, active-high reset
- code_valid  in  1  upstream code available
- code_ready  out  1  block accepts code this cycle
- code_data  in  CODE_W  obstacle voxel code
- code_last  in  1  qualifies code_data as last code of the frame
- chk_code  out  CODE_W  registered code to checker bank inputs A..O
- chk_mask  in  NUM_EDGES  combinational edge_mask outputs of the bank for chk_code
- res_valid  out  1  frame result available
- res_ready  in  1  downstream takes result
- res_blocked  out  NUM_EDGES  bit e = 1: edge e collided with some code in the frame
- res_any  out  1  OR of res_blocked
- res_count  out  CNT_W  codes accepted in the frame, saturating
- res_sat  out  1  res_count saturated during the frame

## Operation
- States: SCAN, FLUSH, HOLD. Reset state: SCAN.
- SCAN: code_ready = 1. A code is accepted on valid&ready; it is loaded into chk_code and pend is set. Otherwise pend is cleared and chk_code holds its value.
- Any cycle with pend = 1: accum |= chk_mask at the edge.
- Accepting a code with code_last = 1 moves the FSM to FLUSH. code_ready is 0 in FLUSH and HOLD.
- FLUSH (one cycle): the last mask is folded, pend clears, and the FSM moves to HOLD.
- HOLD: res_valid = 1. res_blocked = accum, res_any = |accum, res_count and res_sat are stable. On res_ready, accum, count and sat clear and the FSM returns to SCAN.
- Count: +1 per accepted code, saturating at 2^CNT_W−1. res_sat sets on an increment attempted at max.
- An empty frame cannot occur, because code_last always accompanies a code.
- Reset mid-frame: all state clears asynchronously and the partial frame is discarded. No res_valid is produced for it.
- Reset values: code_ready 1 (after reset releases), chk_code 0, res_valid 0, res_blocked 0, res_any 0, res_count 0, res_sat 0.

## Timing
- Code accepted at edge k → chk_code updates after k → its mask is folded at edge k+1. The bank's combinational path (chk_code→chk_mask) must close in one cycle.
- Last code accepted at edge k → FLUSH during cycle k..k+1 → res_valid high after edge k+1. Latency is 2 cycles.
- Within a frame the block sustains 1 code/cycle.
- Between frames:
  - The minimum gap is the FLUSH cycle plus one HOLD cycle; res_ready already high gives 2 cycles with code_ready = 0.
  - code_ready rises in the cycle after the res_ready handshake.
- res_ready is ignored outside HOLD. code_valid is ignored outside SCAN.
- Once res_valid is asserted, it and all res_* outputs hold until the handshake completes.

## Structure
- Shared package `prm_pkg`:
  - CODE_W = 15
  - default NUM_EDGES
  - `edge_acc_state_t` enum {SCAN, FLUSH, HOLD}
- Sub-module `prm_mask_accum`: accum register, saturating counter and sat flag, with fold/clear controls.
- The FSM and handshake live in the top.

## Test plan
- One-code frame: code 0x4A15 with last; chk_mask = 0x…0005 in the following cycle → res_valid 2 cycles after acceptance, res_blocked = 0x5, res_any = 1, res_count = 1.
- Back-to-back frame of 4 codes with masks 0x1, 0x2, 0x0, 0x8; res_ready held high → res_blocked = 0xB, res_count = 4, exactly 2 cycles with code_ready = 0, then code_ready = 1.
- All masks 0 over a 10-code frame → res_blocked = 0, res_any = 0, res_count = 10.
- res_ready held low for 5 cycles in HOLD with code_valid high → code_ready stays 0, res_* stable; after the handshake the next frame's accum starts at 0.
- CNT_W = 3, 9-code frame → res_count = 7, res_sat = 1.
- rst pulsed during SCAN after 3 codes → all outputs at reset values immediately; the next 1-code frame reports res_count = 1 and only its own mask.
